// File: rtl/parser_event_monitor.sv
// parser_event_monitor
//   Observation block for the ITCH parser debug path. Each decoder channel's
//   internal-valid pulse is timestamped into a per-channel pending slot. A
//   round-robin arbiter moves one slot per cycle into a first-word-fall-through
//   record FIFO that is drained by a valid/ready stream. Saturating per-channel
//   event counters and a drop counter summarise decoder activity.
//
//   Optional build macro: MON_REF_FILTER_EN adds filter_en_i / filter_ref_i.
//   With filter_en_i=1, only events whose order_ref equals filter_ref_i are
//   captured and counted. Non-matching events are ignored silently.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   mon_en_i              capture enable; the drain path runs regardless
//   clr_i                 synchronous clear of counters and timestamp
//   ch_valid_i            per-channel event pulse
//   ch_order_ref_i        per-channel order_ref, channel i at [i*REF_W +: REF_W]
//   out_valid_o/ready_i   record stream handshake
//   out_ch_o/ref_o/ts_o   head record fields (zero while the FIFO is empty)
//   evt_count_o           per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   drop_count_o          events lost to pending-slot collisions
//   fifo_level_o          record FIFO occupancy

// One pending slot plus its event counter.
module parser_event_monitor_slot #(
  parameter int REF_W = 64,
  parameter int TS_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             cap_i,
  input  logic             gnt_i,
  input  logic [REF_W-1:0] ref_i,
  input  logic [TS_W-1:0]  ts_i,
  output logic             vld_o,
  output logic [REF_W-1:0] ref_o,
  output logic [TS_W-1:0]  ts_o,
  output logic             drop_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             vld_q;
  logic [REF_W-1:0] ref_q;
  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] cnt_q;

  // A slot that is being granted this cycle can take a new event at once.
  assign drop_o = cap_i & vld_q & ~gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      ref_q <= '0;
      ts_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (cap_i && (!vld_q || gnt_i)) begin
        vld_q <= 1'b1;
        ref_q <= ref_i;
        ts_q  <= ts_i;
      end else if (gnt_i) begin
        vld_q <= 1'b0;
      end
      if (clr_i)                       cnt_q <= '0;
      else if (cap_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign vld_o = vld_q;
  assign ref_o = ref_q;
  assign ts_o  = ts_q;
  assign cnt_o = cnt_q;
endmodule

module parser_event_monitor #(
  parameter int NUM_CH     = 6,
  parameter int REF_W      = 64,
  parameter int TS_W       = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          mon_en_i,
  input  logic                          clr_i,
  input  logic [NUM_CH-1:0]             ch_valid_i,
  input  logic [NUM_CH*REF_W-1:0]       ch_order_ref_i,
`ifdef MON_REF_FILTER_EN
  input  logic                          filter_en_i,
  input  logic [REF_W-1:0]              filter_ref_i,
`endif
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NUM_CH)-1:0]     out_ch_o,
  output logic [REF_W-1:0]              out_ref_o,
  output logic [TS_W-1:0]               out_ts_o,
  output logic [NUM_CH*CNT_W-1:0]       evt_count_o,
  output logic [CNT_W-1:0]              drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int DN_W  = $clog2(NUM_CH + 1);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [REF_W-1:0] oref;
    logic [TS_W-1:0]  ts;
  } rec_t;

  logic [TS_W-1:0]              ts_q;
  logic [CH_W-1:0]              rr_q;
  logic [CNT_W-1:0]             drop_q;
  logic [NUM_CH-1:0]            ref_ok, cap, gnt, drop, slot_vld;
  logic [NUM_CH-1:0][REF_W-1:0] slot_ref;
  logic [NUM_CH-1:0][TS_W-1:0]  slot_ts;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;

  rec_t             mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic [LVL_W-1:0] lvl;
  logic             full, push, pop;
  rec_t             push_rec, head;

  // ---------------- capture qualification ----------------
`ifdef MON_REF_FILTER_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_filt
    assign ref_ok[i] = !filter_en_i || (ch_order_ref_i[i*REF_W +: REF_W] == filter_ref_i);
  end
`else
  assign ref_ok = '1;
`endif

  assign cap = {NUM_CH{mon_en_i}} & ch_valid_i & ref_ok;

  // ---------------- per-channel slots ----------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    parser_event_monitor_slot #(.REF_W(REF_W), .TS_W(TS_W), .CNT_W(CNT_W)) u_slot (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .cap_i  (cap[i]),
      .gnt_i  (gnt[i]),
      .ref_i  (ch_order_ref_i[i*REF_W +: REF_W]),
      .ts_i   (ts_q),
      .vld_o  (slot_vld[i]),
      .ref_o  (slot_ref[i]),
      .ts_o   (slot_ts[i]),
      .drop_o (drop[i]),
      .cnt_o  (cnt[i])
    );
  end

  assign evt_count_o = cnt;

  // ---------------- round-robin arbiter ----------------
  function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s -= NUM_CH;
    return s[CH_W-1:0];
  endfunction

  logic            gnt_any, gnt_en;
  logic [CH_W-1:0] gnt_idx, cand;

  // Search starts just past the last winner so every channel gets a turn.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = wrap_idx(rr_q, k);
      if (!gnt_any && slot_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A full FIFO can still accept a record in a cycle that frees its head.
  assign gnt_en = gnt_any & (~full | pop);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_gnt
    assign gnt[i] = gnt_en & (gnt_idx == CH_W'(i));
  end

  // ---------------- drop accounting ----------------
  logic [DN_W-1:0]  drop_n;
  logic [CNT_W:0]   drop_sum;

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_CH; i++) drop_n = drop_n + DN_W'(drop[i]);
    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_n);
  end

  // ---------------- timestamp, pointer, drop counter ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q   <= '0;
      rr_q   <= CH_W'(NUM_CH - 1);
      drop_q <= '0;
    end else begin
      ts_q <= clr_i ? '0 : ts_q + 1'b1;
      if (gnt_en) rr_q <= gnt_idx;
      if (clr_i)              drop_q <= '0;
      else if (drop_sum[CNT_W]) drop_q <= '1;
      else                    drop_q <= drop_sum[CNT_W-1:0];
    end
  end

  assign drop_count_o = drop_q;

  // ---------------- record FIFO ----------------
  assign lvl  = wr_q - rd_q;
  assign full = (lvl == LVL_W'(FIFO_DEPTH));
  assign pop  = out_valid_o & out_ready_i;
  assign push = gnt_en;

  assign push_rec.ch   = gnt_idx;
  assign push_rec.oref = slot_ref[gnt_idx];
  assign push_rec.ts   = slot_ts[gnt_idx];

  // Storage is left unreset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_rec;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  assign head         = mem_q[rd_q[AW-1:0]];
  assign out_valid_o  = (lvl != '0);
  assign out_ch_o     = out_valid_o ? head.ch   : '0;
  assign out_ref_o    = out_valid_o ? head.oref : '0;
  assign out_ts_o     = out_valid_o ? head.ts   : '0;
  assign fifo_level_o = lvl;
endmodule

// File: tb/tb_parser_event_monitor.sv
module tb_parser_event_monitor;
  localparam int NUM_CH = 6, REF_W = 64, TS_W = 32, CNT_W = 32, FIFO_DEPTH = 16;

  logic clk = 1'b0, rst_n = 1'b0, mon_en = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [NUM_CH-1:0]       ch_valid = '0;
  logic [NUM_CH*REF_W-1:0] ch_ref   = '0;
`ifdef MON_REF_FILTER_EN
  logic             filter_en  = 1'b0;
  logic [REF_W-1:0] filter_ref = '0;
`endif
  logic                    out_valid;
  logic [2:0]              out_ch;
  logic [REF_W-1:0]        out_ref;
  logic [TS_W-1:0]         out_ts;
  logic [NUM_CH*CNT_W-1:0] evt_count;
  logic [CNT_W-1:0]        drop_count;
  logic [4:0]              fifo_level;

  parser_event_monitor #(.NUM_CH(NUM_CH), .REF_W(REF_W), .TS_W(TS_W), .CNT_W(CNT_W),
                         .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mon_en_i       (mon_en),
    .clr_i          (clr),
    .ch_valid_i     (ch_valid),
    .ch_order_ref_i (ch_ref),
`ifdef MON_REF_FILTER_EN
    .filter_en_i    (filter_en),
    .filter_ref_i   (filter_ref),
`endif
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_ch_o       (out_ch),
    .out_ref_o      (out_ref),
    .out_ts_o       (out_ts),
    .evt_count_o    (evt_count),
    .drop_count_o   (drop_count),
    .fifo_level_o   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ch;
    logic [63:0] oref;
    logic [31:0] ts;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted head record is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_record: got ch=%0d ref=%0h ts=%0d expected none",
                 out_ch, out_ref, out_ts);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_ch",  64'(out_ch), 64'(mon_e.ch));
        chk("rec_ref", out_ref,     mon_e.oref);
        chk("rec_ts",  64'(out_ts), 64'(mon_e.ts));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ref(input int ch, input logic [63:0] r);
    ch_ref[ch*REF_W +: REF_W] = r;
  endtask

  function automatic logic [63:0] evt(input int ch);
    return 64'(evt_count[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic push_exp(input int ch, input logic [63:0] r, input int ts);
    rec_t e;
    e.ch = 3'(ch);
    e.oref = r;
    e.ts = 32'(ts);
    exp_q.push_back(e);
  endtask

  // After this the timestamp reads 0.
  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // n back-to-back events on channel 0, timestamps 0..n-1, all landing in the FIFO.
  task automatic fill(input int n, input logic [63:0] base);
    do_clr();
    for (int k = 0; k < n; k++) begin
      ch_valid = 6'b000001;
      set_ref(0, base + 64'(k));
      push_exp(0, base + 64'(k), k);
      step();
    end
    ch_valid = '0;
    step();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    chk("rst_out_ref",    out_ref,         64'd0);
    chk("rst_out_ts",     64'(out_ts),     64'd0);
    chk("rst_evt0",       evt(0),          64'd0);
    chk("rst_drop",       64'(drop_count), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    out_ready = 1'b1;
    step();

    // Single event at ts=10, two-cycle latency
    do_clr();
    repeat (10) step();
    ch_valid = 6'b000001;
    set_ref(0, 64'h1234);
    push_exp(0, 64'h1234, 10);
    step();
    ch_valid = '0;
    chk("lat_e0_valid", 64'(out_valid), 64'd0);
    step();
    chk("lat_e1_valid", 64'(out_valid), 64'd1);
    step();
    chk("single_evt0", evt(0), 64'd1);

    // Simultaneous channels 1,3,5 share a timestamp
    do_clr();
    ch_valid = 6'b101010;
    set_ref(1, 64'h11); set_ref(3, 64'h33); set_ref(5, 64'h55);
    push_exp(1, 64'h11, 0); push_exp(3, 64'h33, 0); push_exp(5, 64'h55, 0);
    step();
    ch_valid = '0;
    repeat (5) step();
    chk("simul_drop",    64'(drop_count), 64'd0);
    chk("simul_evt3",    evt(3),          64'd1);
    chk("simul_drained", 64'(exp_q.size()), 64'd0);

    // Monitor disabled: nothing captured or counted
    mon_en = 1'b0;
    ch_valid = 6'b000100;
    step();
    ch_valid = '0;
    mon_en = 1'b1;
    repeat (3) step();
    chk("mon_off_evt2",  evt(2),          64'd0);
    chk("mon_off_level", 64'(fifo_level), 64'd0);

    // Clear coincident with an event: count cleared, event captured at ts=1
    do_clr();
    step();
    clr = 1'b1;
    ch_valid = 6'b010000;
    set_ref(4, 64'h44);
    push_exp(4, 64'h44, 1);
    step();
    clr = 1'b0;
    ch_valid = '0;
    chk("clr_wins_evt4", evt(4), 64'd0);
    repeat (3) step();
    chk("clr_evt_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: 16 records, stable head, then in-order drain
    out_ready = 1'b0;
    fill(16, 64'h100);
    chk("bp_level_full", 64'(fifo_level), 64'd16);
    chk("bp_head_ref",   out_ref,         64'h100);
    repeat (3) step();
    chk("bp_head_stable", out_ref,        64'h100);
    chk("bp_head_ts",     64'(out_ts),    64'd0);
    out_ready = 1'b1;
    repeat (16) step();
    chk("bp_level_empty", 64'(fifo_level),   64'd0);
    chk("bp_drained",     64'(exp_q.size()), 64'd0);

    // Collision against a full FIFO: only the first ch2 event survives
    out_ready = 1'b0;
    fill(16, 64'h200);
    do_clr();
    ch_valid = 6'b000100;
    set_ref(2, 64'hA1);
    push_exp(2, 64'hA1, 0);
    step();
    set_ref(2, 64'hA2);
    step();
    set_ref(2, 64'hA3);
    step();
    ch_valid = '0;
    chk("coll_evt2",  evt(2),          64'd3);
    chk("coll_drop",  64'(drop_count), 64'd2);
    chk("coll_level", 64'(fifo_level), 64'd16);
    out_ready = 1'b1;
    repeat (20) step();
    chk("coll_drained",     64'(exp_q.size()), 64'd0);
    chk("coll_level_empty", 64'(fifo_level),   64'd0);

    // Asynchronous reset mid-burst
    out_ready = 1'b0;
    fill(5, 64'h300);
    ch_valid = 6'b000011;
    set_ref(1, 64'h301);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid),  64'd0);
    chk("arst_level",     64'(fifo_level), 64'd0);
    chk("arst_evt0",      evt(0),          64'd0);
    chk("arst_out_ref",   out_ref,         64'd0);
    exp_q.delete();
    ch_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    chk("arst_after_valid", 64'(out_valid),  64'd0);
    chk("arst_after_level", 64'(fifo_level), 64'd0);

`ifdef MON_REF_FILTER_EN
    // Reference filter: 0xBB is ignored without counting as a drop
    filter_en = 1'b1;
    filter_ref = 64'hAA;
    do_clr();
    ch_valid = 6'b000001;
    set_ref(0, 64'hAA);
    push_exp(0, 64'hAA, 0);
    step();
    set_ref(0, 64'hBB);
    step();
    set_ref(0, 64'hAA);
    push_exp(0, 64'hAA, 2);
    step();
    ch_valid = '0;
    repeat (4) step();
    chk("filt_evt0",    evt(0),            64'd2);
    chk("filt_drop",    64'(drop_count),   64'd0);
    chk("filt_drained", 64'(exp_q.size()), 64'd0);
    filter_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
